// File: rtl/hex_updown_counter_p.sv
// rtl/hex_updown_counter_p.sv - up/down counter with modulus, wrap/saturate, load and hex display
// Optional leading-zero blanking of the hex digits when HEX_ZERO_BLANK_EN is defined.
module hex_updown_counter_p #(
   parameter int                WIDTH     = 32,
   parameter int                NDIGITS   = 8,
   parameter longint unsigned   MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   Updown,
   input  logic                   Enable,
   input  logic                   Mode,
   input  logic                   Load,
   input  logic [WIDTH-1:0]       Load_value,
   output logic [WIDTH-1:0]       Count,
   output logic                   Tc,
   output logic [7*NDIGITS-1:0]   HEX
);

   localparam logic [WIDTH-1:0] max_c = MAX_COUNT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] one   = {{(WIDTH-1){1'b0}}, 1'b1};

   // Tc flags any enabled step attempted at the boundary, even when saturating in place.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         Count <= '0;
         Tc    <= 1'b0;
      end else if (Load) begin
         Count <= (Load_value > max_c) ? max_c : Load_value;
         Tc    <= 1'b0;
      end else if (Enable) begin
         if (Updown) begin
            if (Count == max_c) begin
               Count <= Mode ? max_c : '0;
               Tc    <= 1'b1;
            end else begin
               Count <= Count + one;
               Tc    <= 1'b0;
            end
         end else begin
            if (Count == '0) begin
               Count <= Mode ? '0 : max_c;
               Tc    <= 1'b1;
            end else begin
               Count <= Count - one;
               Tc    <= 1'b0;
            end
         end
      end else begin
         Tc <= 1'b0;
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0:    glyph = 7'b0000001;
         4'h1:    glyph = 7'b1001111;
         4'h2:    glyph = 7'b0010010;
         4'h3:    glyph = 7'b0000110;
         4'h4:    glyph = 7'b1001100;
         4'h5:    glyph = 7'b0100100;
         4'h6:    glyph = 7'b0100000;
         4'h7:    glyph = 7'b0001111;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0000100;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b1100000;
         4'hC:    glyph = 7'b0110001;
         4'hD:    glyph = 7'b1000010;
         4'hE:    glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   endfunction

   logic [3:0] nib;
`ifdef HEX_ZERO_BLANK_EN
   logic       upper_zero;
`endif

   // Walk from the top digit down; nibbles beyond WIDTH shift in as zero.
   always_comb begin
      HEX = '1;
      nib = '0;
`ifdef HEX_ZERO_BLANK_EN
      upper_zero = 1'b1;
`endif
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         nib = 4'(Count >> (4 * i));
`ifdef HEX_ZERO_BLANK_EN
         upper_zero = upper_zero && (nib == 4'h0);
         HEX[7*i +: 7] = (i != 0 && upper_zero) ? 7'b1111111 : glyph(nib);
`else
         HEX[7*i +: 7] = glyph(nib);
`endif
      end
   end

endmodule

// File: tb/tb_hex_updown_counter_p.sv
// tb/tb_hex_updown_counter_p.sv - bench for hex_updown_counter_p across three parameter sets
module tb_hex_updown_counter_p;

   logic        clk = 1'b0;
   logic        rst_n, updown, enable, mode, load;
   logic [31:0] lv;

   logic [7:0]  count_a;  logic tc_a;  logic [27:0] hex_a;
   logic [31:0] count_b;  logic tc_b;  logic [55:0] hex_b;
   logic [4:0]  count_c;  logic tc_c;  logic [20:0] hex_c;

   always #5 clk = ~clk;

   hex_updown_counter_p #(.WIDTH(8), .NDIGITS(4), .MAX_COUNT(99)) dut_a (
      .Clock(clk), .Reset_n(rst_n), .Updown(updown), .Enable(enable), .Mode(mode),
      .Load(load), .Load_value(lv[7:0]), .Count(count_a), .Tc(tc_a), .HEX(hex_a));

   hex_updown_counter_p dut_b (
      .Clock(clk), .Reset_n(rst_n), .Updown(updown), .Enable(enable), .Mode(mode),
      .Load(load), .Load_value(lv), .Count(count_b), .Tc(tc_b), .HEX(hex_b));

   hex_updown_counter_p #(.WIDTH(5), .NDIGITS(3), .MAX_COUNT(31)) dut_c (
      .Clock(clk), .Reset_n(rst_n), .Updown(updown), .Enable(enable), .Mode(mode),
      .Load(load), .Load_value(lv[4:0]), .Count(count_c), .Tc(tc_c), .HEX(hex_c));

   localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
   localparam logic [6:0] G6 = 7'b0100000, G9 = 7'b0000100, GA = 7'b0001000, GF = 7'b0111000;
`ifdef HEX_ZERO_BLANK_EN
   localparam logic [6:0] Z = 7'b1111111;
`else
   localparam logic [6:0] Z = G0;
`endif

   logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   longint unsigned mc  [3] = '{0, 0, 0};
   bit              mt  [3] = '{0, 0, 0};
   longint unsigned mxs [3] = '{99, 64'hFFFF_FFFF, 31};
   longint unsigned lvm [3] = '{64'hFF, 64'hFFFF_FFFF, 64'h1F};

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [63:0] hex_model(input longint unsigned c, input int nd);
      logic [63:0] r;
      int top;
      r   = '0;
      top = 0;
      for (int i = 0; i < nd; i++)
         if (((c >> (4 * i)) & 64'hF) != 0) top = i;
      for (int i = 0; i < nd; i++) begin
         r[7*i +: 7] = glyph_tab[4'((c >> (4 * i)) & 64'hF)];
`ifdef HEX_ZERO_BLANK_EN
         if (i > top) r[7*i +: 7] = 7'b1111111;
`endif
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Applies one edge, advances the reference model for all three instances, and checks them.
   task automatic tick(input bit r, input bit l, input bit e, input bit u, input bit m,
                       input logic [31:0] v);
      rst_n = r; load = l; enable = e; updown = u; mode = m; lv = v;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         longint unsigned c, mx, lk;
         c  = mc[k];
         mx = mxs[k];
         lk = 64'(v) & lvm[k];
         if (!r) begin
            c = 0; mt[k] = 0;
         end else if (l) begin
            c = (lk < mx) ? lk : mx; mt[k] = 0;
         end else if (e) begin
            mt[k] = u ? (c == mx) : (c == 0);
            if (u) c = m ? ((c < mx) ? c + 1 : mx) : (c + 1) % (mx + 1);
            else   c = m ? ((c > 0) ? c - 1 : 0)  : (c + mx) % (mx + 1);
         end else begin
            mt[k] = 0;
         end
         mc[k] = c;
      end
      @(negedge clk);
      chk("a_count", 64'(count_a), 64'(mc[0]));
      chk("a_tc",    64'(tc_a),    64'(mt[0]));
      chk("a_hex",   64'(hex_a),   hex_model(mc[0], 4));
      chk("b_count", 64'(count_b), 64'(mc[1]));
      chk("b_tc",    64'(tc_b),    64'(mt[1]));
      chk("b_hex",   64'(hex_b),   hex_model(mc[1], 8));
      chk("c_count", 64'(count_c), 64'(mc[2]));
      chk("c_tc",    64'(tc_c),    64'(mt[2]));
      chk("c_hex",   64'(hex_c),   hex_model(mc[2], 3));
   endtask

   typedef struct {
      bit          r, l, e, u, m;
      logic [31:0] v;
      int          exp_c;
      bit          exp_t;
      logic [13:0] exp_h;
   } vec_t;

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{1, 0, 1, 0, 0, 32'd0,   99, 1, {G6, G3}};
      tbl[1]  = '{1, 0, 1, 1, 1, 32'd0,   99, 1, {G6, G3}};
      tbl[2]  = '{1, 0, 1, 1, 1, 32'd0,   99, 1, {G6, G3}};
      tbl[3]  = '{1, 0, 1, 1, 1, 32'd0,   99, 1, {G6, G3}};
      tbl[4]  = '{1, 0, 1, 0, 1, 32'd0,   98, 0, {G6, G2}};
      tbl[5]  = '{1, 1, 1, 1, 0, 32'd200, 99, 0, {G6, G3}};
      tbl[6]  = '{1, 1, 1, 1, 0, 32'h2A,  42, 0, {G2, GA}};
      tbl[7]  = '{1, 1, 0, 1, 0, 32'd57,  57, 0, {G3, G9}};
      tbl[8]  = '{0, 1, 1, 1, 0, 32'd10,   0, 0, {Z,  G0}};
      tbl[9]  = '{1, 0, 0, 1, 0, 32'd0,    0, 0, {Z,  G0}};
      tbl[10] = '{1, 0, 1, 0, 1, 32'd0,    0, 1, {Z,  G0}};
      tbl[11] = '{1, 0, 1, 1, 0, 32'd0,    1, 0, {Z,  G1}};
      tbl[12] = '{1, 0, 1, 0, 0, 32'd0,    0, 0, {Z,  G0}};
      tbl[13] = '{1, 0, 1, 0, 0, 32'd0,   99, 1, {G6, G3}};

      tick(0, 0, 0, 0, 0, 32'd0);
      tick(0, 1, 1, 1, 0, 32'd5);
      chk("b_reset_hex", 64'(hex_b), 64'({{7{Z}}, G0}));

      // Wrap-mode count up through the modulus of the 0..99 instance.
      for (int k = 1; k <= 100; k++) begin
         tick(1, 0, 1, 1, 0, 32'd0);
         chk("a_seq_count", 64'(count_a), 64'(k % 100));
         chk("a_seq_tc",    64'(tc_a),    64'(k == 100));
      end
      chk("a_wrap_hex0", 64'(hex_a[6:0]), 64'(G0));

      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].m, tbl[i].v);
         chk($sformatf("tbl%0d_count", i), 64'(count_a),     64'(tbl[i].exp_c));
         chk($sformatf("tbl%0d_tc", i),    64'(tc_a),        64'(tbl[i].exp_t));
         chk($sformatf("tbl%0d_hex", i),   64'(hex_a[13:0]), 64'(tbl[i].exp_h));
      end

      // Five-bit instance counted up to its top value, then over the wrap.
      tick(0, 0, 0, 0, 0, 32'd0);
      for (int k = 0; k < 31; k++) tick(1, 0, 1, 1, 0, 32'd0);
      chk("c_top_count", 64'(count_c), 64'd31);
      chk("c_top_tc",    64'(tc_c),    64'd0);
      chk("c_top_hex",   64'(hex_c),   64'({Z, G1, GF}));
      chk("c_hex_known", 64'($isunknown(hex_c)), 64'd0);
      tick(1, 0, 1, 1, 0, 32'd0);
      chk("c_wrap_count", 64'(count_c), 64'd0);
      chk("c_wrap_tc",    64'(tc_c),    64'd1);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] v;
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 130);
            2:       v = 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: v = $urandom_range(25, 35);
         endcase
         tick($urandom_range(0, 31) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
